// File: rtl/bsg_mem_1r1w_sync_bypass_synth.sv
// 1R1W flop memory with a registered read port, per-bit write mask, optional same-address
// write-to-read bypass, per-entry "written since reset" flags and optional read-data hold.
module bsg_mem_1r1w_sync_bypass_synth_chk (
  input logic clk_i,
  input logic reset_i,
  input logic w_v_i,
  input logic r_v_i,
  input logic w_hit_i,
  input logic r_hit_i
);

  x_on_valids: assert property (@(posedge clk_i) disable iff (reset_i)
    !$isunknown({w_v_i, r_v_i}))
    else $error("bsg_mem_1r1w_sync_bypass_synth: X on w_v_i or r_v_i");

  // Out-of-range accesses are legal but almost always a caller bug, so flag them
  always @(posedge clk_i) begin
    if (!reset_i && w_v_i && !w_hit_i)
      $warning("bsg_mem_1r1w_sync_bypass_synth: write address out of range");
    if (!reset_i && r_v_i && !r_hit_i)
      $warning("bsg_mem_1r1w_sync_bypass_synth: read address out of range");
  end

endmodule

module bsg_mem_1r1w_sync_bypass_synth #(
  parameter int width_p           = 97,
  parameter int els_p             = 2,
  parameter int bypass_p          = 1,
  parameter int latch_last_read_p = 1,
  localparam int addr_width_lp    = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [width_p-1:0]       w_mask_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic                     r_v_o,
  output logic [width_p-1:0]       r_data_o,
  output logic                     r_written_o
);

  localparam bit full_decode_lp = (els_p == 1) || ((32'd1 << addr_width_lp) == els_p);

  logic [width_p-1:0]       mem_r [els_p];
  logic [els_p-1:0]         written_r;
  logic                     w_hit_s, r_hit_s, w_en_s, same_s;
  logic [addr_width_lp-1:0] w_idx_s, r_idx_s;
  logic [width_p-1:0]       w_merged_s, r_data_s;
  logic                     r_written_s;
  logic                     r_v_r, r_written_r;
  logic [width_p-1:0]       r_data_r;

  // Range check only exists when the address space is larger than the array
  if (full_decode_lp) begin : g_full
    assign w_hit_s = 1'b1;
    assign r_hit_s = 1'b1;
  end else begin : g_part
    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);
    assign w_hit_s = (w_addr_i <= last_addr_lp);
    assign r_hit_s = (r_addr_i <= last_addr_lp);
  end

  // A single-entry array ignores the address; out-of-range indices are parked at 0
  assign w_idx_s    = ((els_p == 1) || !w_hit_s) ? {addr_width_lp{1'b0}} : w_addr_i;
  assign r_idx_s    = ((els_p == 1) || !r_hit_s) ? {addr_width_lp{1'b0}} : r_addr_i;
  assign w_en_s     = w_v_i & w_hit_s & ~reset_i;
  assign same_s     = w_v_i & w_hit_s & r_hit_s & (w_idx_s == r_idx_s);
  assign w_merged_s = (mem_r[w_idx_s] & ~w_mask_i) | (w_data_i & w_mask_i);

  // Storage: masked merge into the addressed entry, contents deliberately not reset
  always_ff @(posedge clk_i) begin
    if (w_en_s) begin
      mem_r[w_idx_s] <= w_merged_s;
    end
  end

  // Written flags: set by any in-range write, even one with an all-zero mask
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      written_r <= {els_p{1'b0}};
    end else if (w_en_s) begin
      written_r[w_idx_s] <= 1'b1;
    end
  end

  // Read source select: out-of-range zero, bypassed write, or stored entry
  always_comb begin
    r_data_s    = {width_p{1'b0}};
    r_written_s = 1'b0;
    if (!r_hit_s) begin
      r_data_s    = {width_p{1'b0}};
      r_written_s = 1'b0;
    end else if ((bypass_p != 32'sd0) && same_s) begin
      r_data_s    = w_merged_s;
      r_written_s = 1'b1;
    end else begin
      r_data_s    = mem_r[r_idx_s];
      r_written_s = written_r[r_idx_s];
    end
  end

  // Read output register: capture on request, otherwise hold or clear
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_v_r       <= 1'b0;
      r_data_r    <= {width_p{1'b0}};
      r_written_r <= 1'b0;
    end else begin
      r_v_r <= r_v_i;
      if (r_v_i) begin
        r_data_r    <= r_data_s;
        r_written_r <= r_written_s;
      end else if (latch_last_read_p == 32'sd0) begin
        r_data_r    <= {width_p{1'b0}};
        r_written_r <= 1'b0;
      end
    end
  end

  assign r_v_o       = r_v_r;
  assign r_data_o    = r_data_r;
  assign r_written_o = r_written_r;

  bsg_mem_1r1w_sync_bypass_synth_chk u_chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .w_v_i   (w_v_i),
    .r_v_i   (r_v_i),
    .w_hit_i (w_hit_s),
    .r_hit_i (r_hit_s)
  );

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_bypass_synth.sv
// Two instances (2 entries / bypass / hold, and 3 entries / no bypass / clear) driven by
// shared directed and random stimulus, compared against an array-based reference model.
module tb_bsg_mem_1r1w_sync_bypass_synth;
  localparam int W = 97;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, w_v, r_v;
  logic [W-1:0] w_data, w_mask;
  logic [1:0]   wa, ra;
  logic         rv_a, rw_a, rv_b, rw_b;
  logic [W-1:0] rd_a, rd_b;
  int           total = 0, bad = 0;

  logic [W-1:0] ones_c = {W{1'b1}};
  logic [W-1:0] zero_c = {W{1'b0}};
  logic [W-1:0] ff_c   = 97'hFF;
  logic [W-1:0] five_c = 97'h5;

  bsg_mem_1r1w_sync_bypass_synth #(.width_p(W), .els_p(2), .bypass_p(1), .latch_last_read_p(1)) dut_a (
    .clk_i(clk), .reset_i(reset), .w_v_i(w_v), .w_addr_i(wa[0]), .w_data_i(w_data),
    .w_mask_i(w_mask), .r_v_i(r_v), .r_addr_i(ra[0]), .r_v_o(rv_a), .r_data_o(rd_a),
    .r_written_o(rw_a));

  bsg_mem_1r1w_sync_bypass_synth #(.width_p(W), .els_p(3), .bypass_p(0), .latch_last_read_p(0)) dut_b (
    .clk_i(clk), .reset_i(reset), .w_v_i(w_v), .w_addr_i(wa), .w_data_i(w_data),
    .w_mask_i(w_mask), .r_v_i(r_v), .r_addr_i(ra), .r_v_o(rv_b), .r_data_o(rd_b),
    .r_written_o(rw_b));

  // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b
  int           els_m [2] = '{2, 3};
  bit           byp_m [2] = '{1'b1, 1'b0};
  bit           lat_m [2] = '{1'b1, 1'b0};
  logic [W-1:0] mem_m [2][4];
  logic [W-1:0] kn_m  [2][4];
  bit           wr_m  [2][4];
  logic         ev [2], ew [2];
  logic [W-1:0] ed [2], ek [2];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic model_step(input int k, input int wai, input int rai);
    if (reset) begin
      ev[k] = 1'b0; ed[k] = zero_c; ek[k] = ones_c; ew[k] = 1'b0;
      for (int i = 0; i < 4; i++) wr_m[k][i] = 1'b0;
      return;
    end
    ev[k] = r_v;
    if (r_v) begin
      if (rai >= els_m[k]) begin
        ed[k] = zero_c; ek[k] = ones_c; ew[k] = 1'b0;
      end else if (byp_m[k] && w_v && (wai == rai)) begin
        ed[k] = (mem_m[k][rai] & ~w_mask) | (w_data & w_mask);
        ek[k] = kn_m[k][rai] | w_mask;
        ew[k] = 1'b1;
      end else begin
        ed[k] = mem_m[k][rai]; ek[k] = kn_m[k][rai]; ew[k] = wr_m[k][rai];
      end
    end else if (!lat_m[k]) begin
      ed[k] = zero_c; ek[k] = ones_c; ew[k] = 1'b0;
    end
    if (w_v && (wai < els_m[k])) begin
      mem_m[k][wai] = (mem_m[k][wai] & ~w_mask) | (w_data & w_mask);
      kn_m[k][wai]  = kn_m[k][wai] | w_mask;
      wr_m[k][wai]  = 1'b1;
    end
  endtask

  // Apply one cycle of inputs, advance the model, then sample just after the edge
  task automatic drive(input logic rst, input logic wv, input logic [1:0] wai,
                       input logic [W-1:0] d, input logic [W-1:0] m,
                       input logic rv, input logic [1:0] rai);
    reset = rst; w_v = wv; wa = wai; w_data = d; w_mask = m; r_v = rv; ra = rai;
    model_step(0, int'(wa[0]), int'(ra[0]));
    model_step(1, int'(wa), int'(ra));
    @(posedge clk);
    #1;
    chk("a_v",    W'(rv_a),       W'(ev[0]));
    chk("a_data", rd_a & ek[0],   ed[0] & ek[0]);
    chk("a_wr",   W'(rw_a),       W'(ew[0]));
    chk("b_v",    W'(rv_b),       W'(ev[1]));
    chk("b_data", rd_b & ek[1],   ed[1] & ek[1]);
    chk("b_wr",   W'(rw_b),       W'(ew[1]));
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        kn_m[k][i] = zero_c; wr_m[k][i] = 1'b0; mem_m[k][i] = zero_c;
      end
    reset = 1'b1; w_v = 1'b0; r_v = 1'b0; wa = 2'd0; ra = 2'd0;
    w_data = zero_c; w_mask = zero_c;

    drive(1'b1, 1'b0, 2'd0, zero_c, zero_c, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 2'd0, zero_c, zero_c, 1'b0, 2'd0);
    // Unwritten entries: valid read, written flag clear, data unconstrained
    drive(1'b0, 1'b0, 2'd0, zero_c, zero_c, 1'b1, 2'd0);
    drive(1'b0, 1'b0, 2'd0, zero_c, zero_c, 1'b1, 2'd1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 2'(i), rnd(), ones_c, 1'b0, 2'd0);
    // Full write then read back
    drive(1'b0, 1'b1, 2'd1, ones_c, ones_c, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 2'd0, zero_c, zero_c, 1'b1, 2'd1);
    // Masked write merges over a cleared entry
    drive(1'b0, 1'b1, 2'd0, zero_c, ones_c, 1'b0, 2'd0);
    drive(1'b0, 1'b1, 2'd0, ones_c, ff_c, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 2'd0, zero_c, zero_c, 1'b1, 2'd0);
    // Same-cycle same-address write and read
    drive(1'b0, 1'b1, 2'd0, five_c, ones_c, 1'b1, 2'd0);
    // Read then idle: hold versus clear
    drive(1'b0, 1'b0, 2'd0, zero_c, zero_c, 1'b1, 2'd1);
    repeat (3) drive(1'b0, 1'b0, 2'd0, zero_c, zero_c, 1'b0, 2'd0);
    // Write under reset is dropped and flags stay clear
    drive(1'b1, 1'b1, 2'd1, rnd(), ones_c, 1'b1, 2'd1);
    drive(1'b0, 1'b0, 2'd0, zero_c, zero_c, 1'b1, 2'd1);
    // Out-of-range write and read on the 3-entry instance
    drive(1'b0, 1'b1, 2'd3, ones_c, ones_c, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 2'd0, zero_c, zero_c, 1'b1, 2'd3);
    drive(1'b0, 1'b0, 2'd0, zero_c, zero_c, 1'b1, 2'd2);

    for (int n = 0; n < 600; n++) begin
      logic         rst_v, wv_v, rv_v;
      logic [1:0]   wa_v, ra_v;
      logic [W-1:0] m_v;
      int           sel;
      rst_v = ($urandom_range(0, 49) == 0);
      wv_v  = 1'($urandom_range(0, 1));
      rv_v  = 1'($urandom_range(0, 1));
      wa_v  = 2'($urandom_range(0, 3));
      ra_v  = ($urandom_range(0, 2) == 0) ? wa_v : 2'($urandom_range(0, 3));
      sel   = $urandom_range(0, 3);
      m_v   = (sel == 0) ? ones_c : (sel == 1) ? zero_c : rnd();
      drive(rst_v, wv_v, wa_v, rnd(), m_v, rv_v, ra_v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
